// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI master: FSM states, mode bits
// and the default frame width.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } spi_state_e;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  localparam int SPI_DEF_DATA_W = 16;

endpackage

// File: rtl/spi_master_mode0_if.sv
// Local handshake plus SPI pins of the mode-0 master, bundled together.
// "master" is the view taken by the SPI master block itself; "slave" is
// the view of whatever drives it (local logic plus the SPI device).
interface spi_master_mode0_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              ready;
  logic [DATA_W-1:0] rx_data;
  logic              done;
  logic              SCLK1;
  logic              MOSI1;
  logic              CS1;
  logic              MISO1;

  modport master (
    input  start, tx_data, MISO1,
    output ready, rx_data, done, SCLK1, MOSI1, CS1
  );

  modport slave (
    output start, tx_data, MISO1,
    input  ready, rx_data, done, SCLK1, MOSI1, CS1
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period timer: emits a one-cycle tick every CLK_DIV cycles while
// enabled; the count restarts from zero whenever it is disabled, so the
// first tick lands exactly CLK_DIV cycles after enable rises.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..CLK_DIV-1 while enabled, hold at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);
endmodule

// File: rtl/spi_master_mode0.sv
// SPI mode-0 master: full duplex, MSB first, DATA_W-bit frames, SCLK1
// derived from clk by a half-period tick. Every output is a register.
module spi_master_mode0
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DEF_DATA_W,
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_mode0_if.master  bus
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_e        state_q;
  logic [BW-1:0]     bit_cnt_q;
  logic              tail_q;      // last falling edge done, one low half left
  logic [DATA_W-1:0] tx_sh_q;
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              ready_q;
  logic              done_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              cs_q;
  logic              tick;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  // Frame sequencer: every tick is one SCLK1 half period; rises sample
  // MISO1, falls advance MOSI1. rx_data only changes on a completed frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tail_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sclk_q    <= SPI_CPOL;
      mosi_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_LEAD;
            ready_q   <= 1'b0;
            cs_q      <= 1'b0;
            sclk_q    <= SPI_CPOL;
            tx_sh_q   <= bus.tx_data;
            mosi_q    <= bus.tx_data[DATA_W-1];
            bit_cnt_q <= '0;
            tail_q    <= 1'b0;
          end
        end
        ST_LEAD: begin
          if (tick) begin
            sclk_q  <= ~SPI_CPOL;
            rx_sh_q <= {rx_sh_q[DATA_W-2:0], bus.MISO1};
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (tick) begin
            if (tail_q) begin
              cs_q      <= 1'b1;
              done_q    <= 1'b1;
              rx_data_q <= rx_sh_q;
              tail_q    <= 1'b0;
              state_q   <= ST_GAP;
            end else if (sclk_q != SPI_CPOL) begin
              sclk_q <= SPI_CPOL;
              if (bit_cnt_q == LAST_BIT) begin
                mosi_q <= 1'b0;
                tail_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
                mosi_q    <= tx_sh_q[DATA_W-2];
                tx_sh_q   <= {tx_sh_q[DATA_W-2:0], 1'b0};
              end
            end else begin
              sclk_q  <= ~SPI_CPOL;
              rx_sh_q <= {rx_sh_q[DATA_W-2:0], bus.MISO1};
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.SCLK1   = sclk_q;
  assign bus.MOSI1   = mosi_q;
  assign bus.CS1     = cs_q;
endmodule

// File: tb/tb_spi_master_mode0.sv
// Bench for spi_master_mode0: one instance at CLK_DIV=4, one at CLK_DIV=1.
// Expected timing is taken from the frame timeline (rise k at T0+(2k+1)*D,
// done at T0+(2W+1)*D, ready at T0+(2W+2)*D); expected data is simply the
// word the slave side presented (or the tx word when MISO1 loops MOSI1).
module tb_spi_master_mode0;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  bit   loop_en   = 1'b0;
  logic slave_bit = 1'b0;
  int   sel       = 0;

  spi_master_mode0_if #(.DATA_W(W)) if0 ();
  spi_master_mode0_if #(.DATA_W(W)) if1 ();

  assign if0.MISO1 = loop_en ? if0.MOSI1 : slave_bit;
  assign if1.MISO1 = loop_en ? if1.MOSI1 : slave_bit;

  spi_master_mode0 #(.DATA_W(W), .CLK_DIV(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  spi_master_mode0 #(.DATA_W(W), .CLK_DIV(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Observed signals of the instance under test.
  logic         m_ready, m_done, m_sclk, m_mosi, m_cs;
  logic [W-1:0] m_rx;
  always_comb begin
    m_ready = (sel == 0) ? if0.ready   : if1.ready;
    m_done  = (sel == 0) ? if0.done    : if1.done;
    m_sclk  = (sel == 0) ? if0.SCLK1   : if1.SCLK1;
    m_mosi  = (sel == 0) ? if0.MOSI1   : if1.MOSI1;
    m_cs    = (sel == 0) ? if0.CS1     : if1.CS1;
    m_rx    = (sel == 0) ? if0.rx_data : if1.rx_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [W-1:0] tx);
    if (sel == 0) begin
      if0.start   = s;
      if0.tx_data = tx;
    end else begin
      if1.start   = s;
      if1.tx_data = tx;
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 500; i++) begin
      if (m_ready) return;
      @(negedge clk);
    end
    check("ready_timeout", 32'(m_ready), 32'd1);
  endtask

  // One frame: start at T0, follow every cycle until ready returns.
  task automatic run_frame(input int d, input logic [W-1:0] tx, input logic [W-1:0] mw,
                           input bit lp, input bit pulse);
    int t0, off, rises, dones, done_off, cs_low, rdy_off;
    logic prev;
    logic [W-1:0] exp_rx;
    exp_rx    = lp ? tx : mw;
    loop_en   = lp;
    slave_bit = mw[W-1];
    wait_ready();
    drive(1'b1, tx);
    @(negedge clk);
    t0 = cyc;
    drive(1'b0, W'($urandom));
    check("t0_cs",    32'(m_cs),    32'd0);
    check("t0_sclk",  32'(m_sclk),  32'd0);
    check("t0_mosi",  32'(m_mosi),  32'(tx[W-1]));
    check("t0_ready", 32'(m_ready), 32'd0);
    rises = 0; dones = 0; done_off = -1; cs_low = 1; rdy_off = -1; prev = 1'b0;
    for (int i = 0; i < (2*W+4)*d + 10; i++) begin
      @(negedge clk);
      off = cyc - t0;
      if (pulse && off == 10) drive(1'b1, W'($urandom));
      if (pulse && off == 11) drive(1'b0, W'($urandom));
      if (m_sclk && !prev) begin
        if (rises < W) begin
          check("rise_off", 32'(off), 32'((2*rises+1)*d));
          check("mosi_bit", 32'(m_mosi), 32'(tx[W-1-rises]));
        end
        rises++;
        if (rises < W) slave_bit = mw[W-1-rises];
      end
      prev = m_sclk;
      if (!m_cs) cs_low++;
      if (m_done) begin
        dones++;
        done_off = off;
        check("rx_data", 32'(m_rx), 32'(exp_rx));
        check("mosi_end", 32'(m_mosi), 32'd0);
      end
      if (m_ready) begin
        rdy_off = off;
        break;
      end
    end
    check("rises",    32'(rises),    32'(W));
    check("dones",    32'(dones),    32'd1);
    check("done_off", 32'(done_off), 32'((2*W+1)*d));
    check("cs_low",   32'(cs_low),   32'((2*W+1)*d));
    check("rdy_off",  32'(rdy_off),  32'((2*W+2)*d));
    check("rx_hold",  32'(m_rx),     32'(exp_rx));
    $display("frame div=%0d tx=%04h miso=%04h loop=%0d pulse=%0d rx=%04h done@%0d ready@%0d",
             d, tx, mw, lp, pulse, m_rx, done_off, rdy_off);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, gap, dn;
    bit seen_done;
    logic [W-1:0] r0, r1;
    if0.start = 1'b0; if0.tx_data = '0;
    if1.start = 1'b0; if1.tx_data = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      check("rst_cs",    32'(m_cs),    32'd1);
      check("rst_sclk",  32'(m_sclk),  32'd0);
      check("rst_mosi",  32'(m_mosi),  32'd0);
      check("rst_ready", 32'(m_ready), 32'd1);
      check("rst_done",  32'(m_done),  32'd0);
      check("rst_rx",    32'(m_rx),    32'd0);
    end
    rst = 1'b0;
    sel = 0;
    @(negedge clk);

    run_frame(4, 16'hA5C3, 16'h0000, 1'b1, 1'b0);
    run_frame(4, 16'h1234, 16'h3C5A, 1'b0, 1'b0);
    run_frame(4, 16'h5A5A, 16'hC3A5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      r0 = W'($urandom); r1 = W'($urandom);
      run_frame(4, r0, r1, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Back-to-back frames with start held high.
    loop_en = 1'b1;
    wait_ready();
    drive(1'b1, 16'h0001);
    @(negedge clk);
    t0 = cyc;
    drive(1'b1, 16'h8000);
    dn = 0; gap = 0; seen_done = 1'b0;
    for (int i = 0; i < 400 && dn < 2; i++) begin
      @(negedge clk);
      if (m_done) begin
        dn++;
        check(dn == 1 ? "b2b_rx1" : "b2b_rx2", 32'(m_rx), dn == 1 ? 32'h0001 : 32'h8000);
        if (dn == 1) seen_done = 1'b1;
      end
      if (seen_done && dn == 1) begin
        if (m_cs) gap++;
        else begin
          // GAP lasts CLK_DIV cycles and the IDLE cycle that accepts adds one.
          check("b2b_gap", 32'(gap), 32'd5);
          check("b2b_t1",  32'(cyc - t0), 32'((2*W+2)*4 + 1));
          seen_done = 1'b0;
          drive(1'b0, 16'h0000);
        end
      end
    end
    check("b2b_dones", 32'(dn), 32'd2);
    drive(1'b0, 16'h0000);
    $display("b2b frames=%0d last_rx=%04h", dn, m_rx);

    // CLK_DIV = 1 instance.
    sel = 1;
    #0;
    run_frame(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      r0 = W'($urandom); r1 = W'($urandom);
      run_frame(1, r0, r1, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset in the middle of a frame.
    sel = 0;
    #0;
    loop_en = 1'b1;
    wait_ready();
    drive(1'b1, 16'hBEEF);
    @(negedge clk);
    t0 = cyc;
    drive(1'b0, 16'h0000);
    while (cyc - t0 < 40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_cs",    32'(m_cs),    32'd1);
    check("mid_rst_sclk",  32'(m_sclk),  32'd0);
    check("mid_rst_ready", 32'(m_ready), 32'd1);
    check("mid_rst_done",  32'(m_done),  32'd0);
    check("mid_rst_rx",    32'(m_rx),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_done) dn++;
    end
    check("mid_rst_nodone", 32'(dn), 32'd0);
    check("mid_rst_rx2",    32'(m_rx), 32'd0);
    $display("mid-frame reset dones=%0d rx=%04h", dn, m_rx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
